// File: rtl/up_cnt_pkg.sv
// Shared types and defaults for the modulo-N up counter.
// Optional Gray output enabled by UP_CNT_GRAY_OUT_EN.
package up_cnt_pkg;

  localparam int UC_WIDTH = 4;
  localparam int UC_MOD   = 10;

  typedef enum logic [1:0] {
    UC_IDLE = 2'd0,
    UC_RUN  = 2'd1,
    UC_DONE = 2'd2
  } up_cnt_state_t;

endpackage

// File: rtl/up_cnt_bin2gray.sv
// Combinational binary to Gray code conversion.
// Used by the counter top only under UP_CNT_GRAY_OUT_EN.
module up_cnt_bin2gray #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/sync_up_counter_mod_n.sv
// Synchronous modulo-N up counter, free-run or one-shot.
// Define UP_CNT_GRAY_OUT_EN to add the registered q_gray output.
module sync_up_counter_mod_n
  import up_cnt_pkg::*;
#(
  parameter int WIDTH = UC_WIDTH,
  parameter int MOD   = UC_MOD
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode_oneshot,
  input  logic             start,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             carry_out,
  output logic             busy,
  output logic             done
`ifdef UP_CNT_GRAY_OUT_EN
  ,
  output logic [WIDTH-1:0] q_gray
`endif
);

  // One extra bit so MOD == 2**WIDTH is representable
  localparam logic [WIDTH:0] LAST = (WIDTH+1)'(MOD - 1);

  up_cnt_state_t   state;
  up_cnt_state_t   state_n;
  logic [WIDTH-1:0] q_n;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH-1:0] q_ld;
  logic [WIDTH:0]   q_inc;

  assign tc        = ({1'b0, q} == LAST);
  assign carry_out = en && tc;

  assign q_inc  = {1'b0, q} + 1'b1;
  assign q_step = tc ? '0 : q_inc[WIDTH-1:0];
  assign q_ld   = ({1'b0, load_val} > LAST) ?
                  LAST[WIDTH-1:0] : load_val;

  always_comb begin
    q_n     = q;
    state_n = state;
    if (clr) begin
      q_n     = '0;
      state_n = UC_IDLE;
    end else begin
      if (load) begin
        q_n = q_ld;
      end else begin
        case (state)
          UC_IDLE: begin
            if (mode_oneshot) begin
              if (start) begin
                q_n     = '0;
                state_n = UC_RUN;
              end
            end else if (en) begin
              q_n = q_step;
            end
          end
          UC_RUN: begin
            if (en) begin
              q_n = q_step;
              if (tc) state_n = UC_DONE;
            end
          end
          default: ;
        endcase
      end
      // DONE (and any stray encoding) always falls back to IDLE
      if (state != UC_IDLE && state != UC_RUN)
        state_n = UC_IDLE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q     <= '0;
      state <= UC_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      q     <= q_n;
      state <= state_n;
      busy  <= (state_n == UC_RUN);
      done  <= (state_n == UC_DONE);
    end
  end

`ifdef UP_CNT_GRAY_OUT_EN
  logic [WIDTH-1:0] gray_n;

  up_cnt_bin2gray #(
    .WIDTH (WIDTH)
  ) u_b2g (
    .bin  (q_n),
    .gray (gray_n)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_gray <= '0;
    else       q_gray <= gray_n;
  end
`endif

endmodule

// File: tb/tb_sync_up_counter_mod_n.sv
// Directed self-checking bench for sync_up_counter_mod_n.
// Build with UP_CNT_GRAY_OUT_EN to also check q_gray.
module tb_sync_up_counter_mod_n;

  localparam int W = 4;
  localparam int M = 10;

  logic         clk = 1'b0;
  logic         reset;
  logic         en, clr, load, mode_oneshot, start;
  logic [W-1:0] load_val;
  logic [W-1:0] q, q2;
  logic         tc, tc2, carry, carry2;
  logic         busy, busy2, done, done2;
`ifdef UP_CNT_GRAY_OUT_EN
  logic [W-1:0] g, g2;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sync_up_counter_mod_n #(.WIDTH(W), .MOD(M)) u1 (
    .clk          (clk),
    .reset        (reset),
    .en           (en),
    .clr          (clr),
    .load         (load),
    .load_val     (load_val),
    .mode_oneshot (mode_oneshot),
    .start        (start),
    .q            (q),
    .tc           (tc),
    .carry_out    (carry),
    .busy         (busy),
    .done         (done)
`ifdef UP_CNT_GRAY_OUT_EN
    ,
    .q_gray       (g)
`endif
  );

  sync_up_counter_mod_n #(.WIDTH(W), .MOD(M)) u2 (
    .clk          (clk),
    .reset        (reset),
    .en           (carry),
    .clr          (1'b0),
    .load         (1'b0),
    .load_val     ('0),
    .mode_oneshot (1'b0),
    .start        (1'b0),
    .q            (q2),
    .tc           (tc2),
    .carry_out    (carry2),
    .busy         (busy2),
    .done         (done2)
`ifdef UP_CNT_GRAY_OUT_EN
    ,
    .q_gray       (g2)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    en = 0; clr = 0; load = 0; load_val = '0;
    mode_oneshot = 0; start = 0;
    reset = 1'b1;
    #2;
    checks++;
    if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
        tc !== 1'b0 || carry !== 1'b0) begin
      failures++;
      $display("FAIL reset q=%0d busy=%b done=%b tc=%b co=%b exp 0", q, busy, done, tc, carry);
    end
`ifdef UP_CNT_GRAY_OUT_EN
    checks++;
    if (g !== 4'd0) begin
      failures++;
      $display("FAIL reset_gray got %0d exp 0", g);
    end
`endif
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_freerun();
    logic [W-1:0] e;
    en = 1'b1;
    for (int i = 0; i < 12; i++) begin
      e = W'(i % M);
      checks++;
      if (q !== e || tc !== (e == 9) || carry !== (e == 9) ||
          busy !== 1'b0 || done !== 1'b0) begin
        failures++;
        $display("FAIL freerun i=%0d q=%0d tc=%b co=%b b=%b d=%b exp q=%0d", i, q, tc, carry, busy, done, e);
      end
      tick();
    end
    en = 1'b0;
    tick();
  endtask

  task automatic test_oneshot();
    mode_oneshot = 1'b1;
    start = 1'b1;
    en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < M; i++) begin
      checks++;
      if (q !== W'(i) || busy !== 1'b1 || done !== 1'b0) begin
        failures++;
        $display("FAIL oneshot_run i=%0d q=%0d busy=%b done=%b exp q=%0d busy=1 done=0", i, q, busy, done, i);
      end
      tick();
    end
    checks++;
    if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b1) begin
      failures++;
      $display("FAIL oneshot_done q=%0d busy=%b done=%b exp 0 0 1", q, busy, done);
    end
    tick();
    checks++;
    if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_idle q=%0d busy=%b done=%b exp 0 0 0", q, busy, done);
    end
    tick();
    tick();
    checks++;
    if (q !== 4'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL oneshot_hold q=%0d busy=%b exp 0 0", q, busy);
    end
    en = 1'b0;
  endtask

  task automatic test_load_clr();
    mode_oneshot = 1'b0;
    load = 1'b1;
    load_val = 4'd7;
    tick();
    checks++;
    if (q !== 4'd7) begin
      failures++;
      $display("FAIL load7 got %0d exp 7", q);
    end
    load_val = 4'd13;
    tick();
    checks++;
    if (q !== 4'd9 || tc !== 1'b1) begin
      failures++;
      $display("FAIL load_clamp q=%0d tc=%b exp 9 1", q, tc);
    end
    clr = 1'b1;
    load_val = 4'd3;
    tick();
    checks++;
    if (q !== 4'd0) begin
      failures++;
      $display("FAIL clr_over_load got %0d exp 0", q);
    end
    clr = 1'b0;
    load = 1'b0;
    tick();
  endtask

  task automatic test_en_toggle();
    int e;
    mode_oneshot = 1'b1;
    start = 1'b1;
    en = 1'b0;
    tick();
    start = 1'b0;
    e = 0;
    for (int k = 0; k < 8; k++) begin
      en = (k % 2 == 0);
      if (k == 3) begin
        start = 1'b1;
        mode_oneshot = 1'b0;
      end
      if (en) e++;
      tick();
      start = 1'b0;
      checks++;
      if (q !== W'(e) || busy !== 1'b1) begin
        failures++;
        $display("FAIL en_toggle k=%0d q=%0d busy=%b exp q=%0d busy=1", k, q, busy, e);
      end
    end
    en = 1'b1;
    while (e < M - 1) begin
      tick();
      e++;
    end
    checks++;
    if (q !== 4'd9 || busy !== 1'b1) begin
      failures++;
      $display("FAIL en_toggle_end q=%0d busy=%b exp 9 1", q, busy);
    end
    tick();
    checks++;
    if (q !== 4'd0 || done !== 1'b1) begin
      failures++;
      $display("FAIL en_toggle_done q=%0d done=%b exp 0 1", q, done);
    end
    en = 1'b0;
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL en_toggle_after done=%b busy=%b exp 0 0", done, busy);
    end
  endtask

  task automatic test_async_reset();
    logic seen;
    mode_oneshot = 1'b1;
    start = 1'b1;
    en = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    checks++;
    if (q !== 4'd5 || busy !== 1'b1) begin
      failures++;
      $display("FAIL areset_pre q=%0d busy=%b exp 5 1", q, busy);
    end
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (q !== 4'd0 || busy !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL areset_now q=%0d busy=%b done=%b exp 0 0 0", q, busy, done);
    end
    tick();
    #2;
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0 || q !== 4'd0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      failures++;
      $display("FAIL areset_after q=%0d busy=%b done=%b exp no activity", q, busy, done);
    end
    en = 1'b0;
    mode_oneshot = 1'b0;
  endtask

  task automatic test_cascade();
    en = 1'b0;
    do_reset();
    en = 1'b1;
    for (int i = 0; i < 35; i++) begin
      checks++;
      if (q !== W'(i % M) || q2 !== W'(i / M)) begin
        failures++;
        $display("FAIL cascade i=%0d q1=%0d q2=%0d exp %0d %0d", i, q, q2, i % M, i / M);
      end
`ifdef UP_CNT_GRAY_OUT_EN
      checks++;
      if (g !== (q ^ (q >> 1)) || g2 !== (q2 ^ (q2 >> 1))) begin
        failures++;
        $display("FAIL gray i=%0d g1=%0d g2=%0d q1=%0d q2=%0d", i, g, g2, q, q2);
      end
`endif
      tick();
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_freerun();
    test_oneshot();
    test_load_clr();
    test_en_toggle();
    test_async_reset();
    test_cascade();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
